apb_modport: RTL and testbench

- Top-level APB subsystem: one APB master plus two APB memory slaves, driven by a simple transfer-request interface.
- The testbench issues a transfer with a read/write flag, a write address and data, or a read address. The block performs the APB SETUP/ACCESS sequence and returns read data.
- Address MSB selects slave 1 or slave 2. Each slave is a 2^(AW-1) x DW register memory.

---
 rtl/apb_pkg.sv | 10 +
 rtl/apb_slave.sv | 35 +++
 rtl/apb_modport.sv | 116 +++++++++++
 tb/tb_apb_modport.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared sizing and master state encoding for the APB subsystem.
package apb_pkg;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int MEM_DEPTH = 1 << (AW - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;

endpackage

// File: rtl/apb_slave.sv
// Zero-wait-state APB register memory; the slave sees only the offset bits of the address.
module apb_slave #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [AW-2:0] paddr,
  input  logic [DW-1:0] pwdata,
  output logic [DW-1:0] prdata,
  output logic          pready
);

  localparam int DEPTH = 1 << (AW - 1);

  logic [DW-1:0] mem [DEPTH];

  assign pready = psel & penable;
  assign prdata = pready ? mem[paddr] : '0;

  // Every word clears on reset so a read can never return X.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (pready && pwrite) begin
      mem[paddr] <= pwdata;
    end
  end

endmodule

// File: rtl/apb_modport.sv
// APB master FSM driving two memory slaves selected by the address MSB.
module apb_modport
  import apb_pkg::*;
#(
  parameter int AW = apb_pkg::AW,
  parameter int DW = apb_pkg::DW
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          transfer,
  input  logic          read_write,
  input  logic [AW-1:0] apb_write_paddr,
  input  logic [DW-1:0] apb_write_data,
  input  logic [AW-1:0] apb_read_paddr,
  output logic [DW-1:0] apb_read_data_out
);

  apb_state_t    state;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pwrite;
  logic          psel1;
  logic          psel2;
  logic          penable;
  logic          pready;
  logic          pready1;
  logic          pready2;
  logic [DW-1:0] prdata;
  logic [DW-1:0] prdata1;
  logic [DW-1:0] prdata2;
  logic [AW-1:0] req_addr;
  logic          start;

  assign req_addr = read_write ? apb_read_paddr : apb_write_paddr;
  assign pready   = psel1 ? pready1 : (psel2 ? pready2 : 1'b0);
  assign prdata   = psel1 ? prdata1 : (psel2 ? prdata2 : '0);

  // A request is accepted from IDLE or on the same edge that completes an ACCESS.
  assign start = transfer && ((state == IDLE) || ((state == ACCESS) && pready));

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state             <= IDLE;
      paddr             <= '0;
      pwdata            <= '0;
      pwrite            <= 1'b0;
      psel1             <= 1'b0;
      psel2             <= 1'b0;
      penable           <= 1'b0;
      apb_read_data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (transfer) begin
            state <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            if (!pwrite) begin
              apb_read_data_out <= prdata;
            end
            penable <= 1'b0;
            if (transfer) begin
              state <= SETUP;
            end else begin
              psel1 <= 1'b0;
              psel2 <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (start) begin
        pwrite <= ~read_write;
        paddr  <= req_addr;
        pwdata <= apb_write_data;
        psel1  <= ~req_addr[AW-1];
        psel2  <= req_addr[AW-1];
      end
    end
  end

  apb_slave #(.AW(AW), .DW(DW)) slave1 (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel1),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr[AW-2:0]),
    .pwdata  (pwdata),
    .prdata  (prdata1),
    .pready  (pready1)
  );

  apb_slave #(.AW(AW), .DW(DW)) slave2 (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel2),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr[AW-2:0]),
    .pwdata  (pwdata),
    .prdata  (prdata2),
    .pready  (pready2)
  );

endmodule

// File: tb/tb_apb_modport.sv
// Directed plus randomized bench for apb_modport against a flat 512-word memory model.
module tb_apb_modport;
  import apb_pkg::*;

  typedef struct {
    bit         rw;
    logic [8:0] addr;
    logic [7:0] data;
    bit         chain;
  } req_t;

  logic          pclk = 1'b0;
  logic          preset;
  logic          transfer;
  logic          read_write;
  logic [AW-1:0] apb_write_paddr;
  logic [DW-1:0] apb_write_data;
  logic [AW-1:0] apb_read_paddr;
  logic [DW-1:0] apb_read_data_out;

  int checks = 0;
  int failures = 0;

  logic [7:0] model_mem [512];
  logic [7:0] exp_out;
  req_t       reqs [$];

  always #5 pclk = ~pclk;

  apb_modport dut (
    .pclk              (pclk),
    .preset            (preset),
    .transfer          (transfer),
    .read_write        (read_write),
    .apb_write_paddr   (apb_write_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_paddr    (apb_read_paddr),
    .apb_read_data_out (apb_read_data_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    foreach (model_mem[i]) model_mem[i] = 8'h00;
    exp_out = 8'h00;
  endtask

  // Idle/don't-care inputs get junk so the design must rely on latched values.
  task automatic scramble_inputs();
    transfer        = 1'b0;
    read_write      = 1'($urandom);
    apb_write_paddr = 9'($urandom);
    apb_read_paddr  = 9'($urandom);
    apb_write_data  = 8'($urandom);
  endtask

  task automatic drive_req(input req_t r);
    scramble_inputs();
    transfer   = 1'b1;
    read_write = r.rw;
    if (r.rw) begin
      apb_read_paddr = r.addr;
    end else begin
      apb_write_paddr = r.addr;
      apb_write_data  = r.data;
    end
  endtask

  task automatic run_queue();
    req_t r;
    bit   chained = 1'b0;
    while (reqs.size() > 0) begin
      r = reqs.pop_front();
      if (!chained) begin
        @(negedge pclk);
        drive_req(r);
        @(posedge pclk);
      end
      @(negedge pclk);
      check("setup_psel1", dut.psel1, !r.addr[8]);
      check("setup_psel2", dut.psel2, r.addr[8]);
      check("setup_penable", dut.penable, 1'b0);
      scramble_inputs();
      @(posedge pclk);
      @(negedge pclk);
      check("access_penable", dut.penable, 1'b1);
      check("access_psel", dut.psel1 | dut.psel2, 1'b1);
      chained = r.chain && (reqs.size() > 0);
      if (chained) drive_req(reqs[0]);
      @(posedge pclk);
      #1;
      if (r.rw) exp_out = model_mem[r.addr];
      else model_mem[r.addr] = r.data;
      check("read_data_out", apb_read_data_out, exp_out);
      if (!chained) begin
        check("idle_psel", {dut.psel1, dut.psel2, dut.penable}, 3'b000);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [8:0] a;
    scramble_inputs();
    clear_model();
    preset = 1'b1;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    check("reset_out", apb_read_data_out, 8'h00);
    check("reset_bus", {dut.psel1, dut.psel2, dut.penable}, 3'b000);
    preset = 1'b0;

    $display("[TB] reads after reset");
    reqs.push_back('{1'b1, 9'h000, 8'h00, 1'b0});
    reqs.push_back('{1'b1, 9'h1FF, 8'h00, 1'b0});
    run_queue();

    $display("[TB] slave 1 write/read and slave isolation");
    reqs.push_back('{1'b0, 9'h012, 8'h05, 1'b0});
    reqs.push_back('{1'b1, 9'h012, 8'h00, 1'b0});
    reqs.push_back('{1'b0, 9'h112, 8'hA5, 1'b0});
    reqs.push_back('{1'b1, 9'h012, 8'h00, 1'b0});
    reqs.push_back('{1'b1, 9'h112, 8'h00, 1'b0});
    run_queue();

    $display("[TB] idle hold");
    repeat (10) begin
      scramble_inputs();
      @(posedge pclk);
      @(negedge pclk);
      check("idle_hold_out", apb_read_data_out, 8'hA5);
      check("idle_hold_bus", {dut.psel1, dut.psel2, dut.penable}, 3'b000);
    end

    $display("[TB] back-to-back");
    reqs.push_back('{1'b0, 9'h0FF, 8'h3C, 1'b1});
    reqs.push_back('{1'b1, 9'h0FF, 8'h00, 1'b1});
    reqs.push_back('{1'b0, 9'h1FF, 8'hC3, 1'b1});
    reqs.push_back('{1'b1, 9'h1FF, 8'h00, 1'b0});
    run_queue();

    $display("[TB] reset mid-transfer");
    reqs.push_back('{1'b1, 9'h0FF, 8'h00, 1'b0});
    run_queue();
    @(negedge pclk);
    drive_req('{1'b0, 9'h020, 8'h77, 1'b0});
    @(posedge pclk);
    @(negedge pclk);
    preset   = 1'b1;
    transfer = 1'b0;
    #1;
    clear_model();
    check("midreset_state", 32'(dut.state), 32'(IDLE));
    check("midreset_bus", {dut.psel1, dut.psel2, dut.penable}, 3'b000);
    check("midreset_out", apb_read_data_out, exp_out);
    @(negedge pclk);
    preset = 1'b0;
    reqs.push_back('{1'b1, 9'h020, 8'h00, 1'b0});
    reqs.push_back('{1'b1, 9'h0FF, 8'h00, 1'b0});
    run_queue();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 80; i++) begin
      a = 9'($urandom) & 9'h10F;
      reqs.push_back('{1'($urandom), a, 8'($urandom), 1'($urandom)});
    end
    run_queue();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
